// File: rtl/fcs_strip_ctrl.sv
// fcs_strip_ctrl: strips the trailing HOLD_BYTES bytes (FCS) from each frame.
// The last HOLD_BYTES accepted bytes are kept in a shift store, so a payload
// byte is only released once it is certain not to be part of the FCS.
// Frames of HOLD_BYTES bytes or fewer produce no output.
// The output error flag is the OR of every in_err seen in the frame,
// including the discarded FCS bytes.
//
// Build option: define FCS_STRIP_STATS_EN to implement the saturating
// frame_cnt / runt_cnt statistics. Without it both outputs are tied to zero
// and the datapath is unchanged.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no byte of the current frame held (fill = 0)
// FILL   | 0 < fill < HOLD_BYTES, nothing can be released yet
// STREAM | store full; each accept releases the oldest held byte
// DROP   | one-cycle flush after in_last: clear fill and sticky error
module fcs_strip_ctrl #(
    parameter int DATA_W     = 8,
    parameter int HOLD_BYTES = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  runt_cnt
);

    localparam int FILL_W = $clog2(HOLD_BYTES + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HOLD_BYTES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DROP   = 2'd3;

    logic [1:0]        state;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_inc;
    logic [DATA_W-1:0] hold_q [HOLD_BYTES];
    logic              err_sticky;
    logic              accept;
    logic              load;

    // Input is blocked while the output register is stuck or during the flush.
    assign in_ready = (!out_valid || out_ready) && (state != ST_DROP);
    assign accept   = in_valid && in_ready;
    // Only a full store guarantees the oldest byte is payload, not FCS.
    assign load     = accept && (state == ST_STREAM);
    assign fill_inc = fill + FILL_W'(1);

    // Frame-position state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_FILL: begin
                    if (accept) begin
                        if (in_last)
                            state <= ST_DROP;
                        else if (fill_inc == FILL_MAX)
                            state <= ST_STREAM;
                        else
                            state <= ST_FILL;
                    end
                end
                ST_STREAM: begin
                    if (accept && in_last)
                        state <= ST_DROP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of bytes held for the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fill <= '0;
        else if (state == ST_DROP)
            fill <= '0;
        else if (accept && (fill < FILL_MAX))
            fill <= fill_inc;
    end

    // Shift store: slot 0 newest, slot HOLD_BYTES-1 oldest; moves only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HOLD_BYTES; i++)
                hold_q[i] <= '0;
        end else if (accept) begin
            hold_q[0] <= in_data;
            for (int i = 1; i < HOLD_BYTES; i++)
                hold_q[i] <= hold_q[i-1];
        end
    end

    // Sticky error accumulates over the whole frame, FCS bytes included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_sticky <= 1'b0;
        else if (state == ST_DROP)
            err_sticky <= 1'b0;
        else if (accept)
            err_sticky <= err_sticky | in_err;
    end

    // Output register: load on STREAM accept, otherwise drain when taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= hold_q[HOLD_BYTES-1];
            out_last  <= in_last;
            out_err   <= in_last & (err_sticky | in_err);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FCS_STRIP_STATS_EN
    logic runt_evt;
    logic frame_evt;

    // A last byte arriving before the store is full means nothing was sent.
    assign runt_evt  = accept && in_last && (state != ST_STREAM);
    assign frame_evt = load && in_last;

    // Saturating frame / runt statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            runt_cnt  <= '0;
        end else begin
            if (frame_evt && !(&frame_cnt))
                frame_cnt <= frame_cnt + CNT_W'(1);
            if (runt_evt && !(&runt_cnt))
                runt_cnt <= runt_cnt + CNT_W'(1);
        end
    end
`else
    assign frame_cnt = '0;
    assign runt_cnt  = '0;
`endif

endmodule

// File: tb/tb_fcs_strip_ctrl.sv
// Testbench for fcs_strip_ctrl (HOLD_BYTES=4, DATA_W=8).
// Frames are described as beat queues; a frame-level model computes the
// expected payload (all but the last HOLD_BYTES bytes, error = OR of frame)
// and the expected statistics.
module tb_fcs_strip_ctrl;

    localparam int HOLD = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       e;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_err;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_err;
    logic [15:0] frame_cnt;
    logic [15:0] runt_cnt;

    fcs_strip_ctrl #(.DATA_W(8), .HOLD_BYTES(HOLD), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_err    (in_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err),
        .frame_cnt (frame_cnt),
        .runt_cnt  (runt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t in_q[$];
    beat_t exp_q[$];
    int    n_checks   = 0;
    int    n_errors   = 0;
    int    frames_exp = 0;
    int    runts_exp  = 0;
    int    cyc        = 0;
    int    acc_cnt    = 0;
    int    gap_pct    = 0;
    bit    bp_rand    = 0;
    int    stall_start = -1000;
    bit    stall_prev = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame-level model: payload is everything except the last HOLD bytes.
    task automatic queue_frame(input int len, input int base, input bit rnd,
                               input int err_idx, input int err_pct);
        beat_t fr[$];
        bit    any_err = 0;
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = rnd ? 8'($urandom) : 8'(base + i);
            b.l = (i == len - 1);
            b.e = (i == err_idx) || (err_pct > 0 && $urandom_range(99) < err_pct);
            any_err |= b.e;
            fr.push_back(b);
            in_q.push_back(b);
        end
        if (len > HOLD) begin
            for (int i = 0; i < len - HOLD; i++) begin
                b.d = fr[i].d;
                b.l = (i == len - HOLD - 1);
                b.e = b.l && any_err;
                exp_q.push_back(b);
            end
            frames_exp++;
        end else begin
            runts_exp++;
        end
    endtask

    // One clock: outputs sampled and inputs driven at the falling edge.
    task automatic step();
        beat_t exp_b;
        @(negedge clk);
        if (stall_prev)
            check_val("stall_hold_valid", out_valid, 1'b1);
        if (in_q.size() != 0 && $urandom_range(99) >= gap_pct) begin
            in_valid = 1'b1;
            in_data  = in_q[0].d;
            in_last  = in_q[0].l;
            in_err   = in_q[0].e;
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'b0;
            in_err   = 1'b0;
        end
        out_ready = (bp_rand ? ($urandom_range(3) != 0) : 1'b1)
                    && !(cyc >= stall_start && cyc < stall_start + 10);
        #1;
        if (out_valid && !out_ready)
            check_val("in_ready_backpressure", in_ready, 1'b0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", out_valid, 1'b0);
            end else begin
                exp_b = exp_q.pop_front();
                check_val("out_data", out_data, exp_b.d);
                check_val("out_last", out_last, exp_b.l);
                if (exp_b.l)
                    check_val("out_err", out_err, exp_b.e);
            end
        end
        if (in_valid && in_ready) begin
            void'(in_q.pop_front());
            acc_cnt++;
        end
        stall_prev = out_valid && !out_ready;
        cyc++;
    endtask

    task automatic check_counters(input string tag);
`ifdef FCS_STRIP_STATS_EN
        check_val({tag, "_frame_cnt"}, frame_cnt, frames_exp);
        check_val({tag, "_runt_cnt"}, runt_cnt, runts_exp);
`else
        check_val({tag, "_frame_cnt"}, frame_cnt, 0);
        check_val({tag, "_runt_cnt"}, runt_cnt, 0);
`endif
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0 || out_valid) && n < budget) begin
            step();
            n++;
        end
        check_val({tag, "_drained"}, (n < budget), 1'b1);
        repeat (3) step();
        check_counters(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        in_err    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_data", out_data, 8'h00);
        check_val("rst_out_last", out_last, 1'b0);
        check_val("rst_out_err", out_err, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_counters("rst");
        rst_n = 1'b1;

        // 64-byte frame 0x00..0x3F
        queue_frame(64, 8'h00, 0, -1, 0);
        run_until_idle("frame64", 500);

        // runt followed by a 10-byte frame
        queue_frame(3, 8'hE0, 0, -1, 0);
        queue_frame(10, 8'h10, 0, -1, 0);
        run_until_idle("runt_then_10", 200);

        // exactly HOLD and HOLD+1 bytes
        queue_frame(4, 8'h50, 0, -1, 0);
        queue_frame(5, 8'hA0, 0, -1, 0);
        run_until_idle("hold_edge", 200);

        // 10-cycle output stall mid-frame
        stall_start = cyc + 20;
        queue_frame(64, 8'h00, 0, -1, 0);
        run_until_idle("stall", 500);
        stall_start = -1000;

        // error only on the last FCS byte
        queue_frame(64, 8'h00, 0, 63, 0);
        run_until_idle("fcs_err", 500);

        // reset shortly after byte 20 of a frame
        acc_cnt = 0;
        queue_frame(30, 8'h00, 0, -1, 0);
        for (int n = 0; n < 200 && acc_cnt < 21; n++)
            step();
        check_val("reached_byte20", (acc_cnt >= 21), 1'b1);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("midrst_out_valid", out_valid, 1'b0);
        check_val("midrst_out_data", out_data, 8'h00);
        in_q.delete();
        exp_q.delete();
        stall_prev = 0;
        frames_exp = 0;
        runts_exp  = 0;
        check_counters("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        queue_frame(8, 8'h00, 0, -1, 0);
        run_until_idle("after_rst", 200);

        // randomized traffic with gaps, backpressure and errors
        bp_rand = 1;
        gap_pct = 30;
        for (int f = 0; f < 40; f++)
            queue_frame($urandom_range(20, 1), 0, 1, -1, 8);
        run_until_idle("random", 20000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fcs_strip_ctrl.md
FCS_STRIP_CTRL -- requirements
Module: fcs_strip_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: byte-lane width of in_data/out_data.
REQ-002 SHALL have parameter HOLD_BYTES, default 4 (min 1): trailing bytes withheld and discarded per frame (FCS length).
REQ-003 SHALL have parameter CNT_W, default 16: width of statistics counters.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream byte present.
REQ-007 in_ready  output  1  block accepts byte this cycle.
REQ-008 in_data  input  DATA_W  upstream byte.
REQ-009 in_last  input  1  final byte of frame (FCS last byte).
REQ-010 in_err  input  1  PHY/decode error flag on this byte.
REQ-011 out_valid  output  1  registered output byte present.
REQ-012 out_ready  input  1  downstream accepts output byte.
REQ-013 out_data  output  DATA_W  payload byte.
REQ-014 out_last  output  1  final payload byte of frame.
REQ-015 out_err  output  1  frame had an error; valid only with out_last.
REQ-016 frame_cnt  output  CNT_W  frames delivered with payload.
REQ-017 runt_cnt  output  CNT_W  frames dropped as too short.

Function
REQ-018 Accept = in_valid && in_ready; in_ready SHALL be (!out_valid || out_ready) && state != DROP.
REQ-019 Internal HOLD_BYTES-deep shift storage SHALL shift exactly on accept: new byte into slot 0, slot i-1 to slot i, no shift otherwise.
REQ-020 fill counter (0..HOLD_BYTES) SHALL increment on accept while < HOLD_BYTES, saturate at HOLD_BYTES.
REQ-021 States: IDLE (fill=0), FILL (0<fill<HOLD_BYTES), STREAM (fill=HOLD_BYTES), DROP (one-cycle flush).
REQ-022 IDLE->FILL on accept without in_last; FILL->STREAM when accept makes fill=HOLD_BYTES; any state->DROP on accept with in_last; DROP->IDLE unconditionally next cycle, clearing fill and sticky error.
REQ-023 In STREAM, accept SHALL load output register with oldest slot (slot HOLD_BYTES-1), out_valid=1 next cycle; latency: payload byte k appears one cycle after byte k+HOLD_BYTES accepted.
REQ-024 out_last SHALL equal in_last of the accepting beat; out_err on that beat SHALL be OR of all in_err in frame including the HOLD_BYTES discarded bytes.
REQ-025 out_valid SHALL clear when out_ready=1 and no new load; simultaneous drain and load SHALL keep out_valid=1 with new byte.
REQ-026 Output register contents SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 in_last accepted while fill<HOLD_BYTES (frame <= HOLD_BYTES bytes) SHALL emit nothing and increment runt_cnt.
REQ-028 Frame of HOLD_BYTES+1 bytes SHALL emit exactly one byte with out_last=1.
REQ-029 frame_cnt SHALL increment when out_last byte is loaded; both counters SHALL saturate at all-ones.
REQ-030 Withheld bytes SHALL never reach out_data.

Reset
REQ-031 On rst_n=0, immediately: state IDLE, fill 0, storage 0, out_valid 0, out_data 0, out_last 0, out_err 0, sticky error 0, counters 0.
REQ-032 Reset mid-frame SHALL discard partial frame; next accepted byte after release starts a new frame.

Configuration
REQ-033 Macro FCS_STRIP_STATS_EN defined: frame_cnt/runt_cnt implemented per REQ-027/029.
REQ-034 Macro absent: counter logic omitted, frame_cnt and runt_cnt tied to 0; datapath unchanged.

Verification
REQ-035 64-byte frame 0x00..0x3F, HOLD_BYTES=4, out_ready=1 -> 60 bytes 0x00..0x3B, out_last on 0x3B, out_err=0, frame_cnt=1.
REQ-036 3-byte frame -> no out_valid, runt_cnt=1; following 10-byte frame 0x10..0x19 -> 0x10..0x15 delivered.
REQ-037 5-byte frame 0xA0..0xA4 -> single byte 0xA0 with out_last=1.
REQ-038 out_ready=0 for 10 cycles mid-frame -> in_ready=0 after output register fills, out_data stable, no byte lost or duplicated.
REQ-039 in_err=1 on byte 63 only (FCS) -> out_err=1 with out_last on byte 59.
REQ-040 rst_n low 1 cycle after byte 20 of frame -> out_valid=0 immediately; next 8-byte frame 0x00..0x07 yields 0x00..0x03 only.
